// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, default widths and address-width helper for the register file
package regfile_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } hilo_state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_REGS   = 32;

  // A depth of 2 still needs one address bit, which $clog2 alone would not give for 1.
  function automatic int addr_width(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/hilo_scoreboard.sv
// rtl/hilo_scoreboard.sv - one-deep MULT/DIV result tracker with HI/LO registers, stall and sticky error
module hilo_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    hilo_issue,
  input  logic                    hilo_valid,
  input  logic [2*DATA_WIDTH-1:0] hilo_data,
  output logic                    hilo_ready,
  input  logic                    hilo_read,
  output logic [DATA_WIDTH-1:0]   hi,
  output logic [DATA_WIDTH-1:0]   lo,
  output logic                    hilo_busy,
  output logic                    stall,
  output logic                    err
);

  hilo_state_e           state;
  hilo_state_e           next_state;
  logic                  load;
  logic                  err_set;
  logic [DATA_WIDTH-1:0] hi_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic                  err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (hilo_valid) err_set = 1'b1;
        if (hilo_issue) next_state = BUSY;
      end
      BUSY: begin
        if (hilo_valid) begin
          load = 1'b1;
          // An issue landing with the result keeps the slot occupied for the next op.
          if (!hilo_issue) next_state = IDLE;
        end else if (hilo_issue) begin
          err_set = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (load) begin
        hi_q <= hilo_data[2*DATA_WIDTH-1:DATA_WIDTH];
        lo_q <= hilo_data[DATA_WIDTH-1:0];
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign hilo_busy  = (state == BUSY);
  assign hilo_ready = hilo_busy;
  assign hi         = load ? hilo_data[2*DATA_WIDTH-1:DATA_WIDTH] : hi_q;
  assign lo         = load ? hilo_data[DATA_WIDTH-1:0] : lo_q;
  assign stall      = hilo_read && hilo_busy && !(hilo_valid && hilo_ready);
  assign err        = err_q;

endmodule

// File: rtl/regfile_hilo_scb.sv
// rtl/regfile_hilo_scb.sv - 3-read/1-write register file with bypass, zero register and HI/LO scoreboard
module regfile_hilo_scb
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS   = DEFAULT_NUM_REGS,
  parameter int ADDR_WIDTH = addr_width(NUM_REGS),
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   rs_addr,
  input  logic [ADDR_WIDTH-1:0]   rt_addr,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rs_data,
  output logic [DATA_WIDTH-1:0]   rt_data,
  output logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    hilo_issue,
  input  logic                    hilo_valid,
  input  logic [2*DATA_WIDTH-1:0] hilo_data,
  output logic                    hilo_ready,
  input  logic                    hilo_read,
  output logic [DATA_WIDTH-1:0]   hi,
  output logic [DATA_WIDTH-1:0]   lo,
  output logic                    hilo_busy,
  output logic                    stall,
  output logic                    err
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic                  wr_accept;

  assign wr_accept = wr_en && !((ZERO_REG != 0) && (rd_addr == '0));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_accept) begin
      mem[rd_addr] <= wr_data;
    end
  end

  // Zero register wins over bypass so r0 stays 0 even while being written.
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    if ((ZERO_REG != 0) && (addr == '0))
      return '0;
    else if ((BYPASS != 0) && wr_en && (addr == rd_addr))
      return wr_data;
    else
      return mem[addr];
  endfunction

  always_comb begin
    rs_data = read_port(rs_addr);
    rt_data = read_port(rt_addr);
    rd_data = read_port(rd_addr);
  end

  hilo_scoreboard #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .hilo_issue(hilo_issue),
    .hilo_valid(hilo_valid),
    .hilo_data (hilo_data),
    .hilo_ready(hilo_ready),
    .hilo_read (hilo_read),
    .hi        (hi),
    .lo        (lo),
    .hilo_busy (hilo_busy),
    .stall     (stall),
    .err       (err)
  );

endmodule

// File: tb/tb_regfile_hilo_scb.sv
// tb/tb_regfile_hilo_scb.sv - randomized scoreboard bench for regfile_hilo_scb against a behavioural model
module tb_regfile_hilo_scb;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  rs_addr = '0, rt_addr = '0, rd_addr = '0;
  logic [31:0] rs_data, rt_data, rd_data;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        hilo_issue = 1'b0, hilo_valid = 1'b0, hilo_read = 1'b0;
  logic [63:0] hilo_data = '0;
  logic        hilo_ready;
  logic [31:0] hi, lo;
  logic        hilo_busy, stall, err;

  regfile_hilo_scb dut (
    .clock(clock), .reset(reset),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .rs_data(rs_data), .rt_data(rt_data), .rd_data(rd_data),
    .wr_en(wr_en), .wr_data(wr_data),
    .hilo_issue(hilo_issue), .hilo_valid(hilo_valid), .hilo_data(hilo_data),
    .hilo_ready(hilo_ready), .hilo_read(hilo_read),
    .hi(hi), .lo(lo), .hilo_busy(hilo_busy), .stall(stall), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rs, rt, rd, hi, lo;
    logic        busy, ready, stall, err;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   driver_done = 1'b0;

  // Behavioural model state
  logic [31:0] m_regs [32];
  logic [31:0] m_hi, m_lo;
  bit          m_busy, m_err;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wr_en && a == rd_addr) return wr_data;
    return m_regs[a];
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_hi = '0; m_lo = '0; m_busy = 0; m_err = 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
  endtask

  // Applies one cycle of stimulus, queues the expected response, then advances the model.
  task automatic step(input logic rst, input logic wen, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [31:0] wd, input logic issue,
                      input logic valid, input logic [63:0] hd, input logic rdreq);
    exp_t e;
    reset = rst; wr_en = wen; rs_addr = rs; rt_addr = rt; rd_addr = rd; wr_data = wd;
    hilo_issue = issue; hilo_valid = valid; hilo_data = hd; hilo_read = rdreq;
    if (!rst) m_clear();
    e.rs    = m_read(rs);
    e.rt    = m_read(rt);
    e.rd    = m_read(rd);
    e.hi    = (m_busy && valid) ? hd[63:32] : m_hi;
    e.lo    = (m_busy && valid) ? hd[31:0]  : m_lo;
    e.busy  = m_busy;
    e.ready = m_busy;
    e.stall = rdreq && m_busy && !valid;
    e.err   = m_err;
    expq.push_back(e);
    if (rst) begin
      if (wen && rd != 5'd0) m_regs[rd] = wd;
      if (m_busy) begin
        if (valid) begin
          m_hi = hd[63:32]; m_lo = hd[31:0];
          m_busy = issue;
        end else if (issue) begin
          m_err = 1;
        end
      end else begin
        if (valid) m_err = 1;
        if (issue) m_busy = 1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic rdreq);
    step(1, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 0, 64'd0, rdreq);
  endtask

  // Monitor: compares every presented cycle against the head of the expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("rs_data", rs_data, e.rs);
        check("rt_data", rt_data, e.rt);
        check("rd_data", rd_data, e.rd);
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("hilo_busy", {31'd0, hilo_busy}, {31'd0, e.busy});
        check("hilo_ready", {31'd0, hilo_ready}, {31'd0, e.ready});
        check("stall", {31'd0, stall}, {31'd0, e.stall});
        check("err", {31'd0, err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    m_clear();
    @(posedge clock);
    #1;
    // Reset, then read 0/5/31
    step(0, 0, 5'd0, 5'd5, 5'd31, 32'd0, 0, 0, 64'd0, 0);
    step(1, 0, 5'd0, 5'd5, 5'd31, 32'd0, 0, 0, 64'd0, 0);
    // Write with same-cycle bypass, then registered read
    step(1, 1, 5'd7, 5'd3, 5'd7, 32'hDEADBEEF, 0, 0, 64'd0, 0);
    step(1, 0, 5'd3, 5'd7, 5'd9, 32'd0, 0, 0, 64'd0, 0);
    // Zero register
    step(1, 1, 5'd0, 5'd7, 5'd0, 32'h12345678, 0, 0, 64'd0, 0);
    step(1, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 0, 64'd0, 0);
    // Multi-cycle result with stalled reader
    step(1, 0, 5'd0, 5'd0, 5'd0, 32'd0, 1, 0, 64'd0, 0);
    repeat (3) idle(1);
    step(1, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 1, 64'h00000001_FFFFFFFE, 1);
    idle(1);
    // Back-to-back: result and new issue together
    step(1, 0, 5'd0, 5'd0, 5'd0, 32'd0, 1, 0, 64'd0, 0);
    step(1, 1, 5'd4, 5'd4, 5'd4, 32'hA5A5A5A5, 1, 1, 64'h11112222_33334444, 1);
    step(1, 0, 5'd4, 5'd0, 5'd0, 32'd0, 0, 1, 64'h55556666_77778888, 0);
    idle(0);
    // Protocol errors, then reset mid-BUSY
    step(1, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 1, 64'hFFFFFFFF_FFFFFFFF, 0);
    step(1, 0, 5'd0, 5'd0, 5'd0, 32'd0, 1, 0, 64'd0, 0);
    step(1, 0, 5'd0, 5'd0, 5'd0, 32'd0, 1, 0, 64'd0, 1);
    step(0, 0, 5'd4, 5'd7, 5'd0, 32'd0, 0, 0, 64'd0, 1);
    idle(0);
    // Random traffic; addresses drawn from a small set so bypass collisions are frequent
    for (int i = 0; i < 600; i++) begin
      logic [4:0] a0, a1, a2;
      a0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      a2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      step(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)), a0, a1, a2, $urandom,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
    driver_done = 1'b1;
  end

  initial begin
    int guard;
    guard = 0;
    while (!driver_done && guard < 5000) begin
      @(posedge clock);
      guard++;
    end
    if (!driver_done) begin
      n_checks++;
      $display("FAIL timeout: driver_done=%0d, expected 1", driver_done);
    end
    repeat (2) @(negedge clock);
    #1;
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
